// File: rtl/pmem_arb_pkg.sv
// Shared types and constants for the program-memory warp arbiter.
package pmem_arb_pkg;

  // Arbiter sequencing: accept a grant, issue it, wait for memory, answer the warps.
  typedef enum logic [1:0] {
    StIdle,
    StRequest,
    StWait,
    StRespond
  } arb_state_e;

  // Bit positions of each warp in the grant set; also the encoding of the round-robin pointer.
  localparam int unsigned NumWarps = 2;
  localparam int unsigned Warp1Idx = 0;
  localparam int unsigned Warp2Idx = 1;

endpackage

// File: rtl/pmem_warp_arbiter.sv
// Two-warp arbiter in front of a single program-memory read port. Identical
// addresses are merged into one access; differing addresses are served
// round-robin, so a losing warp waits for at most one access.
module pmem_warp_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic                             warp_1_read_valid,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] warp_1_read_address,
  output logic                             warp_1_read_ready,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] warp_1_read_data,

  input  logic                             warp_2_read_valid,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] warp_2_read_address,
  output logic                             warp_2_read_ready,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] warp_2_read_data,

  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,

  output logic [15:0]                      fetch_count,
  output logic [15:0]                      merge_count
);

  arb_state_e                       r_state;
  logic                             r_ptr;    // holds Warp1Idx or Warp2Idx: who wins a conflict
  logic [NumWarps-1:0]              r_grant;
  logic                             r_mem_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_addr;
  logic                             r_w1_ready;
  logic                             r_w2_ready;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_w1_data;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_w2_data;
  logic [15:0]                      r_fetch_count;
  logic [15:0]                      r_merge_count;

  logic [NumWarps-1:0]              w_grant;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] w_addr;

  // Grant selection evaluated against the live warp requests; only used in StIdle.
  always_comb begin
    w_grant = '0;
    w_addr  = '0;
    unique case ({warp_2_read_valid, warp_1_read_valid})
      2'b01: begin
        w_grant[Warp1Idx] = 1'b1;
        w_addr            = warp_1_read_address;
      end
      2'b10: begin
        w_grant[Warp2Idx] = 1'b1;
        w_addr            = warp_2_read_address;
      end
      2'b11: begin
        if (warp_1_read_address == warp_2_read_address) begin
          w_grant = '1;
          w_addr  = warp_1_read_address;
        end else if (r_ptr == 1'(Warp1Idx)) begin
          w_grant[Warp1Idx] = 1'b1;
          w_addr            = warp_1_read_address;
        end else begin
          w_grant[Warp2Idx] = 1'b1;
          w_addr            = warp_2_read_address;
        end
      end
      default: ;
    endcase
  end

  // Arbiter FSM with all outputs registered; mem_read_ready only matters in StWait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_ptr         <= 1'(Warp1Idx);
      r_grant       <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_addr    <= '0;
      r_w1_ready    <= 1'b0;
      r_w2_ready    <= 1'b0;
      r_w1_data     <= '0;
      r_w2_data     <= '0;
      r_fetch_count <= '0;
      r_merge_count <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|w_grant) begin
            r_grant     <= w_grant;
            r_mem_addr  <= w_addr;
            r_mem_valid <= 1'b1;
            r_state     <= StRequest;
          end
        end
        StRequest: begin
          r_state <= StWait;
        end
        StWait: begin
          if (mem_read_ready) begin
            r_mem_valid <= 1'b0;
            r_w1_ready  <= r_grant[Warp1Idx];
            r_w2_ready  <= r_grant[Warp2Idx];
            // Ungranted warps keep their previous instruction on the data bus.
            if (r_grant[Warp1Idx]) r_w1_data <= mem_read_data;
            if (r_grant[Warp2Idx]) r_w2_data <= mem_read_data;
            r_state     <= StRespond;
          end
        end
        StRespond: begin
          r_w1_ready    <= 1'b0;
          r_w2_ready    <= 1'b0;
          r_fetch_count <= r_fetch_count + 16'd1;
          if (&r_grant) begin
            r_merge_count <= r_merge_count + 16'd1;
          end else begin
            // Hand priority to the warp that was not just served.
            r_ptr <= r_grant[Warp1Idx] ? 1'(Warp2Idx) : 1'(Warp1Idx);
          end
          r_grant <= '0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign mem_read_valid    = r_mem_valid;
  assign mem_read_address  = r_mem_addr;
  assign warp_1_read_ready = r_w1_ready;
  assign warp_2_read_ready = r_w2_ready;
  assign warp_1_read_data  = r_w1_data;
  assign warp_2_read_data  = r_w2_data;
  assign fetch_count       = r_fetch_count;
  assign merge_count       = r_merge_count;

endmodule

// File: tb/tb_pmem_warp_arbiter.sv
// Scoreboard bench for pmem_warp_arbiter: expected ready pulses are queued
// when requests are driven and compared as the arbiter answers.
module tb_pmem_warp_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          w1_valid, w2_valid;
  logic [AW-1:0] w1_addr, w2_addr;
  logic          w1_ready, w2_ready;
  logic [DW-1:0] w1_data, w2_data;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [DW-1:0] mem_data;
  logic [15:0]   fetch_count, merge_count;

  always #5 clk = ~clk;

  pmem_warp_arbiter #(
    .PROGRAM_MEM_ADDR_BITS(AW),
    .PROGRAM_MEM_DATA_BITS(DW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .warp_1_read_valid  (w1_valid),
    .warp_1_read_address(w1_addr),
    .warp_1_read_ready  (w1_ready),
    .warp_1_read_data   (w1_data),
    .warp_2_read_valid  (w2_valid),
    .warp_2_read_address(w2_addr),
    .warp_2_read_ready  (w2_ready),
    .warp_2_read_data   (w2_data),
    .mem_read_valid     (mem_valid),
    .mem_read_address   (mem_addr),
    .mem_read_ready     (mem_ready),
    .mem_read_data      (mem_data),
    .fetch_count        (fetch_count),
    .merge_count        (merge_count)
  );

  typedef struct packed {
    logic [1:0]    mask;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_fetch = '0;
  logic [15:0] exp_merge = '0;
  logic        exp_ptr_w2 = 1'b0;
  int          mem_delay = 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 8'h05) return 16'hA1B2;
    return {a ^ 8'h5A, ~a};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_grant(input logic [1:0] mask, input logic [AW-1:0] addr);
    sb.push_back('{mask: mask, data: mem_word(addr)});
    exp_fetch = exp_fetch + 16'd1;
    if (mask == 2'b11) exp_merge = exp_merge + 16'd1;
    else exp_ptr_w2 = (mask == 2'b01);
  endtask

  task automatic expect_conflict(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    if (!exp_ptr_w2) begin
      expect_grant(2'b01, a1);
      expect_grant(2'b10, a2);
    end else begin
      expect_grant(2'b10, a2);
      expect_grant(2'b01, a1);
    end
  endtask

  // Hold a request until its ready pulse (or drop it early after drop_after cycles).
  task automatic warp_req(input int w, input logic [AW-1:0] addr, input int drop_after);
    logic got;
    got = 1'b0;
    if (w == 1) begin w1_valid = 1'b1; w1_addr = addr; end
    else        begin w2_valid = 1'b1; w2_addr = addr; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (i == drop_after) begin
        if (w == 1) w1_valid = 1'b0; else w2_valid = 1'b0;
      end
      if ((w == 1) ? w1_ready : w2_ready) got = 1'b1;
    end
    if (w == 1) w1_valid = 1'b0; else w2_valid = 1'b0;
    check_eq($sformatf("warp%0d_ready_seen", w), 32'(got), 1);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  // Memory model: answers mem_delay cycles after it first sees a request.
  initial begin
    logic [AW-1:0] a;
    logic          stable, rst_seen;
    int            d;
    mem_ready = 1'b0;
    mem_data  = 16'hDEAD;
    forever begin
      @(posedge clk); #1;
      if (mem_valid && reset) begin
        a        = mem_addr;
        d        = mem_delay;
        stable   = 1'b1;
        rst_seen = 1'b0;
        for (int i = 0; i < d; i++) begin
          @(posedge clk); #1;
          if (!reset) rst_seen = 1'b1;
          if (!rst_seen && (!mem_valid || mem_addr != a)) stable = 1'b0;
        end
        mem_ready = 1'b1;
        mem_data  = mem_word(a);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_data  = 16'hDEAD;
        if (!rst_seen) begin
          check_eq("mem_req_held_stable", 32'(stable), 1);
          check_eq("ready_one_cycle_after_mem", 32'(w1_ready | w2_ready), 1);
          check_eq("mem_valid_dropped", 32'(mem_valid), 0);
        end
      end
    end
  end

  // Response monitor: every ready pulse must match the head of the scoreboard.
  initial begin
    logic [1:0] prev, cur;
    exp_t       e;
    prev = '0;
    forever begin
      @(posedge clk); #1;
      cur = {w2_ready, w1_ready};
      if (cur != 2'b00) begin
        if (prev != 2'b00) check_eq("ready_pulse_width", 32'(cur), 0);
        if (sb.size() == 0) begin
          check_eq("spurious_ready", 32'(cur), 0);
        end else begin
          e = sb.pop_front();
          check_eq("grant_mask", 32'(cur), 32'(e.mask));
          if (e.mask[0]) check_eq("w1_data", 32'(w1_data), 32'(e.data));
          if (e.mask[1]) check_eq("w2_data", 32'(w2_data), 32'(e.data));
        end
      end
      prev = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    w1_valid = 1'b0; w2_valid = 1'b0;
    w1_addr  = '0;   w2_addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_valid", 32'(mem_valid), 0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);
    check_eq("rst_ready", 32'({w2_ready, w1_ready}), 0);
    check_eq("rst_data", 32'({w2_data, w1_data}), 0);
    check_eq("rst_counts", {fetch_count, merge_count}, 0);
    @(negedge clk) reset = 1'b1;

    // Single request, fastest memory.
    @(negedge clk);
    expect_grant(2'b01, 8'h05);
    warp_req(1, 8'h05, -1);
    settle();
    check_eq("single_fetch_count", 32'(fetch_count), 32'(exp_fetch));
    check_eq("w1_data_held", 32'(w1_data), 32'h0000A1B2);
    check_eq("w2_data_untouched", 32'(w2_data), 0);

    // Merge: same address from both warps in the same cycle.
    @(negedge clk);
    expect_grant(2'b11, 8'h10);
    fork
      warp_req(1, 8'h10, -1);
      warp_req(2, 8'h10, -1);
    join
    settle();
    check_eq("merge_fetch_count", 32'(fetch_count), 32'(exp_fetch));
    check_eq("merge_count", 32'(merge_count), 32'(exp_merge));

    // Conflicts, twice back-to-back; order follows the round-robin pointer.
    repeat (2) begin
      @(negedge clk);
      expect_conflict(8'h10, 8'h20);
      fork
        warp_req(1, 8'h10, -1);
        warp_req(2, 8'h20, -1);
      join
      settle();
      check_eq("conflict_fetch_count", 32'(fetch_count), 32'(exp_fetch));
    end

    // Slow memory, and warp 2 dropping valid mid-access.
    mem_delay = 7;
    @(negedge clk);
    expect_grant(2'b10, 8'h44);
    warp_req(2, 8'h44, 2);
    settle();
    check_eq("slow_fetch_count", 32'(fetch_count), 32'(exp_fetch));
    mem_delay = 1;

    // Reset during WAIT followed by a late mem_read_ready.
    mem_delay = 12;
    @(negedge clk);
    w1_valid = 1'b1;
    w1_addr  = 8'h30;
    for (int i = 0; i < 20 && !mem_valid; i++) begin
      @(posedge clk); #1;
    end
    check_eq("rst_test_req_issued", 32'(mem_valid), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    w1_valid = 1'b0;
    #1;
    check_eq("async_rst_mem_valid", 32'(mem_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("midrst_mem", {15'b0, mem_valid, 8'b0, mem_addr}, 0);
    check_eq("midrst_ready", 32'({w2_ready, w1_ready}), 0);
    check_eq("midrst_data", {w2_data, w1_data}, 0);
    check_eq("midrst_counts", {fetch_count, merge_count}, 0);
    @(negedge clk) reset = 1'b1;
    exp_fetch  = '0;
    exp_merge  = '0;
    exp_ptr_w2 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("late_ready_ignored_valid", 32'(mem_valid), 0);
    check_eq("late_ready_ignored_count", 32'(fetch_count), 0);
    mem_delay = 1;

    // Normal service after reset; pointer must be back on warp 1.
    @(negedge clk);
    expect_conflict(8'h10, 8'h20);
    fork
      warp_req(1, 8'h10, -1);
      warp_req(2, 8'h20, -1);
    join
    settle();
    check_eq("post_rst_fetch_count", 32'(fetch_count), 32'(exp_fetch));

    // Counter wrap: preload the access count just below 2^16.
    @(negedge clk);
    force dut.r_fetch_count = 16'hFFFE;
    @(posedge clk); #1;
    release dut.r_fetch_count;
    exp_fetch = 16'hFFFE;
    check_eq("preload_fetch_count", 32'(fetch_count), 32'(exp_fetch));
    @(negedge clk);
    expect_conflict(8'h22, 8'h33);
    fork
      warp_req(1, 8'h22, -1);
      warp_req(2, 8'h33, -1);
    join
    settle();
    check_eq("wrap_fetch_count", 32'(fetch_count), 32'(exp_fetch));
    check_eq("wrap_merge_count", 32'(merge_count), 32'(exp_merge));
    check_eq("scoreboard_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
